// File: rtl/upsp_frame_sequencer.sv
// Frame sequencer for the upsampler: gates source beats, marks line and frame ends on the
// destination stream, and posts a one-shot UPENDR write to the register file at frame end.
//
// state | meaning
// IDLE  | waiting for a start pulse
// RUN   | frame in progress, counting source and destination beats
// UPEND | last destination beat accepted, waiting for the register-file write port
module upsp_frame_sequencer #(
  parameter int SRC_IMG_WIDTH  = 960,
  parameter int SRC_IMG_HEIGHT = 540,
  parameter int DST_IMG_WIDTH  = 3840,
  parameter int DST_IMG_HEIGHT = 2160,
  parameter int CRF_DATA_WIDTH = 32,
  parameter int CRF_ADDR_WIDTH = 2,
  parameter int UPENDR_ADDR    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      src_fire,
  input  logic                      dst_fire,
  input  logic                      crf_ac_wbusy,
  output logic                      src_en,
  output logic                      dst_last,
  output logic                      dst_eof,
  output logic                      busy,
  output logic                      err,
  output logic                      ac_crf_wrt,
  output logic [CRF_ADDR_WIDTH-1:0] ac_crf_waddr,
  output logic [CRF_DATA_WIDTH-1:0] ac_crf_wdata
);

  localparam int SRC_TOTAL = SRC_IMG_WIDTH * SRC_IMG_HEIGHT;
  localparam int SRC_CNT_W = $clog2(SRC_TOTAL + 1);
  localparam int DX_W      = $clog2(DST_IMG_WIDTH + 1);
  localparam int DY_W      = $clog2(DST_IMG_HEIGHT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_UPEND = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [SRC_CNT_W-1:0] src_cnt;
  logic [DX_W-1:0]      dst_x;
  logic [DY_W-1:0]      dst_y;
  logic                 wr_go;
  logic                 start_acc;
  logic                 abort_acc;

  assign busy      = (state == ST_RUN) || (state == ST_UPEND);
  assign src_en    = (state == ST_RUN) && (src_cnt < SRC_CNT_W'(SRC_TOTAL));
  assign dst_last  = (state == ST_RUN) && (dst_x == DX_W'(DST_IMG_WIDTH - 1));
  assign dst_eof   = dst_last && (dst_y == DY_W'(DST_IMG_HEIGHT - 1));
  assign start_acc = (state == ST_IDLE) && start;
  assign abort_acc = busy && abort;

  always_comb begin
    state_nxt = state;
    wr_go     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort)                    state_nxt = ST_IDLE;
        else if (dst_fire && dst_eof) state_nxt = ST_UPEND;
      end
      ST_UPEND: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (!crf_ac_wbusy) begin
          state_nxt = ST_IDLE;
          wr_go     = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Start clears err; a fire error coincident with an accepted start or abort is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_cnt <= '0;
      dst_x   <= '0;
      dst_y   <= '0;
      err     <= 1'b0;
    end else if (start_acc) begin
      src_cnt <= '0;
      dst_x   <= '0;
      dst_y   <= '0;
      err     <= 1'b0;
    end else if (abort_acc) begin
      src_cnt <= '0;
      dst_x   <= '0;
      dst_y   <= '0;
    end else begin
      if (src_fire) begin
        if (src_en) src_cnt <= src_cnt + SRC_CNT_W'(1);
        else        err     <= 1'b1;
      end
      if (dst_fire) begin
        if (state == ST_RUN) begin
          if (dst_x == DX_W'(DST_IMG_WIDTH - 1)) begin
            dst_x <= '0;
            dst_y <= dst_y + DY_W'(1);
          end else begin
            dst_x <= dst_x + DX_W'(1);
          end
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_crf_wrt   <= 1'b0;
      ac_crf_waddr <= '0;
      ac_crf_wdata <= '0;
    end else begin
      ac_crf_wrt   <= wr_go;
      ac_crf_waddr <= wr_go ? CRF_ADDR_WIDTH'(UPENDR_ADDR) : '0;
      ac_crf_wdata <= wr_go ? CRF_DATA_WIDTH'(1) : '0;
    end
  end

endmodule

// File: tb/tb_upsp_frame_sequencer.sv
// Randomized bench for upsp_frame_sequencer on a 4x2 -> 16x8 frame; expectations come from
// beat counts (accepted source beats, destination beat index) rather than the RTL structure.
module tb_upsp_frame_sequencer;

  localparam int SW = 4, SH = 2, DW = 16, DH = 8;
  localparam int SRC_N = SW * SH;
  localparam int DST_N = DW * DH;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, src_fire, dst_fire, crf_ac_wbusy;
  logic        src_en, dst_last, dst_eof, busy, err, ac_crf_wrt;
  logic [1:0]  ac_crf_waddr;
  logic [31:0] ac_crf_wdata;

  int checks = 0;
  int fails  = 0;

  upsp_frame_sequencer #(
    .SRC_IMG_WIDTH (SW),
    .SRC_IMG_HEIGHT(SH),
    .DST_IMG_WIDTH (DW),
    .DST_IMG_HEIGHT(DH),
    .CRF_DATA_WIDTH(32),
    .CRF_ADDR_WIDTH(2),
    .UPENDR_ADDR   (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .src_fire    (src_fire),
    .dst_fire    (dst_fire),
    .crf_ac_wbusy(crf_ac_wbusy),
    .src_en      (src_en),
    .dst_last    (dst_last),
    .dst_eof     (dst_eof),
    .busy        (busy),
    .err         (err),
    .ac_crf_wrt  (ac_crf_wrt),
    .ac_crf_waddr(ac_crf_waddr),
    .ac_crf_wdata(ac_crf_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (src_en !== 1'b0) begin fails++; $display("FAIL rst_src_en: got %b want 0", src_en); end
    checks++; if ({dst_last, dst_eof, err} !== 3'b000) begin fails++; $display("FAIL rst_flags: got %b want 000", {dst_last, dst_eof, err}); end
    checks++; if ({ac_crf_wrt, ac_crf_waddr, ac_crf_wdata} !== 35'd0) begin fails++; $display("FAIL rst_crf: got %h want 0", {ac_crf_wrt, ac_crf_waddr, ac_crf_wdata}); end
    checks++; if ({dut.src_cnt, dut.dst_x, dut.dst_y} !== '0) begin fails++; $display("FAIL rst_cnt: got %h want 0", {dut.src_cnt, dut.dst_x, dut.dst_y}); end
  endtask

  // Runs a whole frame with random beat timing, then holds the write port busy for `stall` cycles.
  task automatic test_full_frame(input int stall);
    int s = 0, d = 0, lasts = 0, wrts = 0;
    crf_ac_wbusy = (stall > 0);
    pulse_start();
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL ff_busy_start: got %b want 1", busy); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL ff_err_start: got %b want 0", err); end
    for (int cyc = 0; d < DST_N && cyc < 3000; cyc++) begin
      src_fire = (s < SRC_N) && ($urandom_range(0, 1) == 1);
      dst_fire = ($urandom_range(0, 2) != 0) && !(d == DST_N - 1 && s < SRC_N);
      checks++; if (src_en !== (s < SRC_N)) begin fails++; $display("FAIL ff_src_en: got %b want %b s=%0d", src_en, (s < SRC_N), s); end
      checks++; if (dst_last !== (d % DW == DW - 1)) begin fails++; $display("FAIL ff_dst_last: got %b want %b beat=%0d", dst_last, (d % DW == DW - 1), d); end
      checks++; if (dst_eof !== (d == DST_N - 1)) begin fails++; $display("FAIL ff_dst_eof: got %b want %b beat=%0d", dst_eof, (d == DST_N - 1), d); end
      checks++; if (busy !== 1'b1 || ac_crf_wrt !== 1'b0) begin fails++; $display("FAIL ff_run: busy=%b wrt=%b want 1/0", busy, ac_crf_wrt); end
      if (dst_fire && dst_last) lasts++;
      tick();
      if (src_fire) s++;
      if (dst_fire) d++;
    end
    src_fire = 1'b0;
    dst_fire = 1'b0;
    checks++; if (lasts != DH) begin fails++; $display("FAIL ff_last_count: got %0d want %0d", lasts, DH); end
    checks++; if (src_en !== 1'b0 || dst_last !== 1'b0) begin fails++; $display("FAIL ff_upend_outs: src_en=%b last=%b want 0/0", src_en, dst_last); end
    for (int i = 0; i < stall; i++) begin
      checks++; if (ac_crf_wrt !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL ff_stall: wrt=%b busy=%b want 0/1 cyc=%0d", ac_crf_wrt, busy, i); end
      tick();
    end
    crf_ac_wbusy = 1'b0;
    checks++; if (ac_crf_wrt !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL ff_pre_wr: wrt=%b busy=%b want 0/1", ac_crf_wrt, busy); end
    tick();
    checks++; if (ac_crf_wrt !== 1'b1 || ac_crf_waddr !== 2'd1 || ac_crf_wdata !== 32'd1) begin fails++; $display("FAIL ff_write: wrt=%b addr=%0d data=%0d want 1/1/1", ac_crf_wrt, ac_crf_waddr, ac_crf_wdata); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL ff_busy_end: got %b want 0", busy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ac_crf_wrt) wrts++;
      checks++; if (ac_crf_waddr !== 2'd0 || ac_crf_wdata !== 32'd0 || busy !== 1'b0) begin fails++; $display("FAIL ff_after: addr=%0d data=%0d busy=%b want 0/0/0", ac_crf_waddr, ac_crf_wdata, busy); end
    end
    checks++; if (wrts != 0) begin fails++; $display("FAIL ff_extra_wrt: got %0d extra writes want 0", wrts); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL ff_err_end: got %b want 0", err); end
  endtask

  task automatic test_abort();
    int wrts = 0;
    pulse_start();
    dst_fire = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    dst_fire = 1'b0;
    checks++; if (dut.dst_x !== 5'(40 % DW) || dut.dst_y !== 4'(40 / DW)) begin fails++; $display("FAIL ab_pos: x=%0d y=%0d want %0d/%0d", dut.dst_x, dut.dst_y, 40 % DW, 40 / DW); end
    pulse_abort();
    checks++; if (busy !== 1'b0 || src_en !== 1'b0) begin fails++; $display("FAIL ab_idle: busy=%b src_en=%b want 0/0", busy, src_en); end
    checks++; if ({dut.src_cnt, dut.dst_x, dut.dst_y} !== '0) begin fails++; $display("FAIL ab_cnt: got %h want 0", {dut.src_cnt, dut.dst_x, dut.dst_y}); end
    for (int i = 0; i < 6; i++) begin
      if (ac_crf_wrt) wrts++;
      tick();
    end
    checks++; if (wrts != 0) begin fails++; $display("FAIL ab_no_wrt: got %0d writes want 0", wrts); end
    pulse_abort();
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL ab_idle_abort: busy=%b err=%b want 0/0", busy, err); end
    test_full_frame(0);
  endtask

  task automatic test_errors();
    pulse_start();
    src_fire = 1'b1;
    for (int i = 0; i < SRC_N; i++) tick();
    checks++; if (dut.src_cnt !== 4'd8 || err !== 1'b0 || src_en !== 1'b0) begin fails++; $display("FAIL er_8src: cnt=%0d err=%b en=%b want 8/0/0", dut.src_cnt, err, src_en); end
    tick();
    src_fire = 1'b0;
    checks++; if (dut.src_cnt !== 4'd8 || err !== 1'b1) begin fails++; $display("FAIL er_9th_src: cnt=%0d err=%b want 8/1", dut.src_cnt, err); end
    pulse_start();
    checks++; if (err !== 1'b1 || busy !== 1'b1 || dut.src_cnt !== 4'd8) begin fails++; $display("FAIL er_start_in_run: err=%b busy=%b cnt=%0d want 1/1/8", err, busy, dut.src_cnt); end
    pulse_abort();
    pulse_start();
    checks++; if (err !== 1'b0 || dut.src_cnt !== 4'd0) begin fails++; $display("FAIL er_clear: err=%b cnt=%0d want 0/0", err, dut.src_cnt); end
    pulse_abort();
    dst_fire = 1'b1;
    tick();
    dst_fire = 1'b0;
    checks++; if (err !== 1'b1 || dut.dst_x !== 5'd0 || busy !== 1'b0) begin fails++; $display("FAIL er_dst_idle: err=%b x=%0d busy=%b want 1/0/0", err, dut.dst_x, busy); end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL er_start_wins: err=%b busy=%b want 0/1", err, busy); end
    pulse_abort();
  endtask

  task automatic test_simultaneous();
    int n;
    pulse_start();
    n = $urandom_range(2, 6);
    src_fire = 1'b1;
    dst_fire = 1'b1;
    for (int i = 0; i < n; i++) tick();
    src_fire = 1'b0;
    dst_fire = 1'b0;
    checks++; if (dut.src_cnt !== 4'(n) || dut.dst_x !== 5'(n)) begin fails++; $display("FAIL si_both: src=%0d x=%0d want %0d/%0d", dut.src_cnt, dut.dst_x, n, n); end
    pulse_start();
    checks++; if (dut.src_cnt !== 4'(n) || dut.dst_x !== 5'(n) || busy !== 1'b1) begin fails++; $display("FAIL si_start_ignored: src=%0d x=%0d busy=%b want %0d/%0d/1", dut.src_cnt, dut.dst_x, busy, n, n); end
    pulse_abort();
  endtask

  task automatic test_reset_mid();
    int wrts = 0;
    pulse_start();
    src_fire = 1'b1;
    dst_fire = 1'b1;
    for (int i = 0; i < 70; i++) begin
      if (i == SRC_N) src_fire = 1'b0;
      tick();
    end
    src_fire = 1'b0;
    dst_fire = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    tick();
    #3 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (ac_crf_wrt) wrts++;
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rm_idle: busy=%b want 0", busy); end
      tick();
    end
    checks++; if (wrts != 0) begin fails++; $display("FAIL rm_no_wrt: got %0d writes want 0", wrts); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    src_fire = 1'b0;
    dst_fire = 1'b0;
    crf_ac_wbusy = 1'b0;
    #12;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_full_frame(0);
    test_full_frame(5);
    test_abort();
    test_errors();
    test_simultaneous();
    test_reset_mid();
    test_full_frame($urandom_range(1, 3));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
